// File: rtl/arb_pkg.sv
// Shared encodings for the memory arbiter: FSM states, port indices and
// the default abort timeout.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam int PORT_I          = 0;
    localparam int PORT_D          = 1;
    localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin pick. On a tie the port that did not win
// last time gets the grant; last = 1 means D won most recently.
module rr_arb2
    import arb_pkg::*;
(
    input  logic       i_req,
    input  logic       d_req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (i_req && d_req) begin
            gnt[PORT_I] = last;
            gnt[PORT_D] = ~last;
        end else begin
            gnt[PORT_I] = i_req;
            gnt[PORT_D] = d_req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between an instruction
// fetch port (I) and a data port (D). Optional macro: ARB_TIMEOUT_EN.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        gnt,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state, state_n;
    logic              last, last_n;
    logic [1:0]        pick;
    logic [1:0]        gnt_n;
    logic              mem_req_n, mem_we_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_n, rdata_n;
    logic              i_done_n, d_done_n, err_n;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt, cnt_n;
`endif

    rr_arb2 u_pick (
        .i_req (i_req),
        .d_req (d_req),
        .last  (last),
        .gnt   (pick)
    );

    always_comb begin
        state_n     = state;
        last_n      = last;
        gnt_n       = gnt;
        mem_req_n   = mem_req;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        rdata_n     = rdata;
        i_done_n    = 1'b0;
        d_done_n    = 1'b0;
        err_n       = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_n       = cnt;
`endif
        case (state)
            IDLE: begin
                if (|pick) begin
                    gnt_n       = pick;
                    mem_req_n   = 1'b1;
                    mem_we_n    = pick[PORT_D] & d_we;
                    mem_addr_n  = pick[PORT_D] ? d_addr : i_addr;
                    mem_wdata_n = pick[PORT_D] ? d_wdata : '0;
                    state_n     = WAIT;
`ifdef ARB_TIMEOUT_EN
                    cnt_n       = '0;
`endif
                end
            end
            WAIT: begin
                // Ack wins over a timeout landing in the same cycle.
                if (mem_ack) begin
                    rdata_n   = mem_we ? '0 : mem_rdata;
                    mem_req_n = 1'b0;
                    i_done_n  = gnt[PORT_I];
                    d_done_n  = gnt[PORT_D];
                    last_n    = gnt[PORT_D];
                    state_n   = RESP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    rdata_n   = '0;
                    mem_req_n = 1'b0;
                    i_done_n  = gnt[PORT_I];
                    d_done_n  = gnt[PORT_D];
                    err_n     = 1'b1;
                    last_n    = gnt[PORT_D];
                    state_n   = RESP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
`endif
            end
            RESP: begin
                gnt_n   = 2'b00;
                state_n = IDLE;
            end
            default: begin
                gnt_n     = 2'b00;
                mem_req_n = 1'b0;
                state_n   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            gnt       <= 2'b00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            err       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt       <= '0;
`endif
        end else begin
            state     <= state_n;
            last      <= last_n;
            gnt       <= gnt_n;
            mem_req   <= mem_req_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            rdata     <= rdata_n;
            i_done    <= i_done_n;
            d_done    <= d_done_n;
            err       <= err_n;
`ifdef ARB_TIMEOUT_EN
            cnt       <= cnt_n;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: the bench plays both requesters and
// the memory, predicting grants from the round-robin rule and a memory map.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we, mem_ack;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        i_done, d_done, err, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [1:0]  gnt;

    int checks = 0;
    int errors = 0;
    int m_last = 1;                 // last winner: 0 = I, 1 = D
    logic [31:0] mem [logic [31:0]];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_done    (i_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .rdata     (rdata),
        .gnt       (gnt),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction; the winner is predicted from the request
    // pattern and the previous winner, then the memory acks after dly cycles.
    task automatic txn(input bit ie, input bit de, input bit we,
                       input logic [31:0] ia, input logic [31:0] da,
                       input logic [31:0] wd, input int dly, input bit drop);
        int          w;
        logic        ewe;
        logic [31:0] ea, er;
        w   = (ie && de) ? (m_last == 1 ? 0 : 1) : (ie ? 0 : 1);
        ea  = w ? da : ia;
        ewe = w ? we : 1'b0;
        if (!mem.exists(ea)) mem[ea] = $urandom;
        er  = ewe ? 32'h0 : mem[ea];
        i_req = ie; d_req = de; i_addr = ia; d_addr = da; d_we = we; d_wdata = wd;
        step();
        chk("grant_mem", {mem_req, mem_we, mem_addr}, {1'b1, ewe, ea});
        chk("grant_gnt", {gnt, i_done, d_done}, {(w ? 2'b10 : 2'b01), 2'b00});
        if (ewe) chk("grant_wdata", mem_wdata, wd);
        if (drop) begin i_req = 0; d_req = 0; i_addr = $urandom; d_addr = $urandom; end
        for (int k = 0; k < dly; k++) begin
            step();
            chk("wait_hold", {mem_req, mem_we, mem_addr, gnt, i_done, d_done, err},
                {1'b1, ewe, ea, (w ? 2'b10 : 2'b01), 3'b000});
            if (ewe) chk("wait_wdata", mem_wdata, wd);
        end
        mem_ack = 1'b1;
        mem_rdata = ewe ? $urandom : mem[ea];
        step();
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        if (ewe) mem[ea] = wd;
        chk("done_bits", {i_done, d_done}, (w ? 2'b01 : 2'b10));
        chk("done_rdata", rdata, er);
        chk("done_misc", {err, mem_req, gnt}, {2'b00, (w ? 2'b10 : 2'b01)});
        m_last = w;
        if (w) d_req = 0; else i_req = 0;
        step();
        chk("resp_exit", {gnt, i_done, d_done, mem_req, err}, 6'b0);
    endtask

    initial begin
        rst = 1; i_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl", {gnt, mem_req, mem_we, i_done, d_done, err}, 7'b0);
        chk("reset_data", {mem_addr, mem_wdata}, 64'h0);
        chk("reset_rdata", rdata, 32'h0);
        rst = 0;
        step();

        // Single fetch with fixed data, then a data write held 3 wait cycles.
        mem[32'h40] = 32'h12345678;
        txn(1, 0, 0, 32'h40, 0, 0, 0, 0);
        txn(0, 1, 1, 0, 32'h100, 32'hCAFEF00D, 3, 0);
        txn(0, 1, 0, 0, 32'h100, 0, 1, 0);

        // Contention: both held; grants must alternate I, D, I, D.
        for (int n = 0; n < 4; n++)
            txn(1, 1, 0, 32'h200 + n, 32'h300 + n, 0, n % 2, 0);

        // Requester gives up mid-wait: transaction still completes.
        txn(0, 1, 0, 0, 32'h44, 0, 2, 1);
        txn(1, 0, 0, 32'h48, 0, 0, 1, 1);

        // Stray ack while idle must be ignored.
        mem_ack = 1; mem_rdata = 32'hDEAD;
        step();
        mem_ack = 0;
        chk("idle_ack", {gnt, i_done, d_done, mem_req}, 5'b0);

        // Randomized mix against the round-robin and memory model.
        for (int n = 0; n < 40; n++) begin
            bit ie, de;
            ie = 1'($urandom);
            de = ie ? 1'($urandom) : 1'b1;
            txn(ie, de, 1'($urandom), {28'h0, 4'($urandom)}, {28'h0, 4'($urandom)},
                $urandom, int'($urandom_range(0, 3)), 0);
        end

        // Reset while a data read is outstanding.
        d_req = 1; d_we = 0; d_addr = 32'h80;
        step();
        chk("rst_pre", {mem_req, gnt}, 3'b110);
        rst = 1;
        step();
        rst = 0; d_req = 0;
        chk("rst_mid", {mem_req, gnt, i_done, d_done, err}, 6'b0);
        step();
        chk("rst_after", {mem_req, i_done, d_done}, 3'b0);
        m_last = 1;
        txn(1, 1, 0, 32'h90, 32'h94, 0, 0, 0);
        d_req = 0;

`ifdef ARB_TIMEOUT_EN
        // Read never acked: aborts after the 4th wait cycle.
        d_req = 1; d_we = 0; d_addr = 32'h1C;
        step();
        chk("tmo_grant", {mem_req, gnt}, 3'b110);
        d_req = 0;
        repeat (3) begin
            step();
            chk("tmo_wait", {mem_req, d_done, err}, 3'b100);
        end
        step();
        chk("tmo_done", {d_done, i_done, err, mem_req}, 4'b1010);
        chk("tmo_rdata", rdata, 32'h0);
        m_last = 1;
        step();
        txn(1, 0, 0, 32'h20, 0, 0, 1, 0);

        // Ack on the very cycle the counter expires: normal completion.
        d_req = 1; d_we = 0; d_addr = 32'h24;
        step();
        d_req = 0;
        repeat (3) step();
        mem_ack = 1; mem_rdata = 32'hA5A5A5A5;
        step();
        mem_ack = 0;
        chk("tie_done", {d_done, err}, 2'b10);
        chk("tie_rdata", rdata, 32'hA5A5A5A5);
        m_last = 1;
        step();
`else
        // Without the timeout, an unacked read waits indefinitely.
        d_req = 1; d_we = 0; d_addr = 32'h1C;
        step();
        d_req = 0;
        repeat (20) begin
            step();
            chk("nowait_tmo", {mem_req, i_done, d_done, err}, 4'b1000);
        end
        mem_ack = 1; mem_rdata = 32'h0BADF00D;
        step();
        mem_ack = 0;
        chk("late_ack", {d_done, err, rdata}, {2'b10, 32'h0BADF00D});
        m_last = 1;
        step();
`endif
        txn(1, 1, 0, 32'h30, 32'h34, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Both done bits high together is never legal.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert (!(i_done && d_done)) else begin
                errors++;
                $error("FAIL dual_done: observed %b%b expected not 11", i_done, d_done);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
